// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART receive path.
//   UART_DATA_W   character width
//   UART_ENTRY_W  stored entry width: 10 when UART_RX_FIFO_ERR_EN is defined
//                 (data plus parity/framing flags), otherwise 8 (data only)
//   uart_entry_t  {frm_err, par_err, data}
//   UART_DEPTH / UART_AFULL_LVL  default receive buffer geometry
package uart_pkg;

  localparam int UART_DATA_W = 8;
`ifdef UART_RX_FIFO_ERR_EN
  localparam int UART_ENTRY_W = 10;
`else
  localparam int UART_ENTRY_W = 8;
`endif

  localparam int UART_DEPTH     = 16;
  localparam int UART_AFULL_LVL = 12;

  typedef struct packed {
    logic                   frm_err;
    logic                   par_err;
    logic [UART_DATA_W-1:0] data;
  } uart_entry_t;

  // Width of an occupancy counter that must represent 0..depth inclusive.
  function automatic int uart_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: receive buffer bus.
//   Write side (from the UART receiver): wr_en, wr_data, wr_par_err, wr_frm_err
//   Read side (register bank): rd_en, clr_ovf in; rd_data, rd_par_err,
//   rd_frm_err, rd_valid, empty, full, afull, count, overflow out.
//   master: receiver/register bank side.  slave: the buffer itself.
interface uart_rx_fifo_if #(parameter int DEPTH = uart_pkg::UART_DEPTH);

  localparam int CW = uart_pkg::uart_cnt_w(DEPTH);

  logic          wr_en;
  logic [7:0]    wr_data;
  logic          wr_par_err;
  logic          wr_frm_err;
  logic          rd_en;
  logic          clr_ovf;
  logic [7:0]    rd_data;
  logic          rd_par_err;
  logic          rd_frm_err;
  logic          rd_valid;
  logic          empty;
  logic          full;
  logic          afull;
  logic [CW-1:0] count;
  logic          overflow;

  modport master (
    output wr_en, wr_data, wr_par_err, wr_frm_err, rd_en, clr_ovf,
    input  rd_data, rd_par_err, rd_frm_err, rd_valid,
           empty, full, afull, count, overflow
  );

  modport slave (
    input  wr_en, wr_data, wr_par_err, wr_frm_err, rd_en, clr_ovf,
    output rd_data, rd_par_err, rd_frm_err, rd_valid,
           empty, full, afull, count, overflow
  );

endinterface

// File: rtl/uart_fifo_ram.sv
// uart_fifo_ram: simple dual-port storage, one write port, registered read port.
//   clk, rst          clock, async active-high reset (read register only)
//   we, waddr, wdata  write port
//   re, raddr, rdata  read port; rdata updates only when re, holds otherwise
// A same-edge read and write to one address returns the old contents.
module uart_fifo_ram #(
  parameter int W     = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  // Array is deliberately not reset.
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  always_ff @(posedge clk or posedge rst)
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive character buffer between the UART receiver and the
// APB register bank.
//   clk, rst  clock, async active-high reset
//   bus       uart_rx_fifo_if.slave (write strobe, pop, status, overflow)
// Build option: UART_RX_FIFO_ERR_EN stores parity/framing flags per entry;
// without it entries are data only and rd_par_err/rd_frm_err read 0.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH     = UART_DEPTH,
  parameter int AFULL_LVL = UART_AFULL_LVL
) (
  input  logic           clk,
  input  logic           rst,
  uart_rx_fifo_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = uart_cnt_w(DEPTH);

  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] cnt;
  logic          rvld;
  logic          ovf;
  logic          is_empty, is_full;
  logic          wr_acc, rd_acc, wr_drop;

  assign is_empty = (cnt == '0);
  assign is_full  = (cnt == CW'(DEPTH));

  // A pop frees the slot in the same edge, so a full buffer still accepts a
  // write when paired with a read. Empty is judged before the edge, so a
  // write into an empty buffer never satisfies a same-cycle read.
  assign rd_acc  = bus.rd_en && !is_empty;
  assign wr_acc  = bus.wr_en && (!is_full || bus.rd_en);
  assign wr_drop = bus.wr_en && is_full && !bus.rd_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
      rvld <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      rvld <= rd_acc;
      if (wr_acc) wptr <= wptr + AW'(1);
      if (rd_acc) rptr <= rptr + AW'(1);
      if (wr_acc && !rd_acc)      cnt <= cnt + CW'(1);
      else if (rd_acc && !wr_acc) cnt <= cnt - CW'(1);
      // Drop wins over clear in the same cycle.
      if (wr_drop)          ovf <= 1'b1;
      else if (bus.clr_ovf) ovf <= 1'b0;
    end
  end

`ifdef UART_RX_FIFO_ERR_EN
  uart_entry_t wr_ent, rd_ent;

  assign wr_ent = '{frm_err: bus.wr_frm_err, par_err: bus.wr_par_err, data: bus.wr_data};

  uart_fifo_ram #(.W(UART_ENTRY_W), .DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_acc),
    .waddr (wptr),
    .wdata (wr_ent),
    .re    (rd_acc),
    .raddr (rptr),
    .rdata (rd_ent)
  );

  assign bus.rd_data    = rd_ent.data;
  assign bus.rd_par_err = rd_ent.par_err;
  assign bus.rd_frm_err = rd_ent.frm_err;
`else
  logic [UART_ENTRY_W-1:0] rd_raw;
  logic                    err_unused;

  assign err_unused = bus.wr_par_err ^ bus.wr_frm_err;

  uart_fifo_ram #(.W(UART_ENTRY_W), .DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_acc),
    .waddr (wptr),
    .wdata (bus.wr_data),
    .re    (rd_acc),
    .raddr (rptr),
    .rdata (rd_raw)
  );

  assign bus.rd_data    = rd_raw;
  assign bus.rd_par_err = 1'b0;
  assign bus.rd_frm_err = 1'b0;
`endif

  assign bus.rd_valid = rvld;
  assign bus.count    = cnt;
  assign bus.empty    = is_empty;
  assign bus.full     = is_full;
  assign bus.afull    = (cnt >= CW'(AFULL_LVL));
  assign bus.overflow = ovf;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed checks of the UART receive buffer (DEPTH 16,
// AFULL_LVL 12). Honours UART_RX_FIFO_ERR_EN for the expected error flags.
module tb_uart_rx_fifo;
  import uart_pkg::*;

  localparam int DEPTH = 16;
  localparam int AFL   = 12;
`ifdef UART_RX_FIFO_ERR_EN
  localparam logic EXP_PE = 1'b1;
`else
  localparam logic EXP_PE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   nerr = 0;
  int   nchk = 0;

  uart_rx_fifo_if #(.DEPTH(DEPTH)) bus ();

  uart_rx_fifo #(.DEPTH(DEPTH), .AFULL_LVL(AFL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock with the given inputs; returns 1 time unit after the edge.
  task automatic cyc(input logic we, input logic [7:0] wd, input logic pe,
                     input logic fe, input logic re, input logic co);
    bus.wr_en      = we;
    bus.wr_data    = wd;
    bus.wr_par_err = pe;
    bus.wr_frm_err = fe;
    bus.rd_en      = re;
    bus.clr_ovf    = co;
    @(posedge clk);
    #1;
    bus.wr_en   = 1'b0;
    bus.rd_en   = 1'b0;
    bus.clr_ovf = 1'b0;
  endtask

  initial begin
    bus.wr_en = 0; bus.wr_data = 0; bus.wr_par_err = 0; bus.wr_frm_err = 0;
    bus.rd_en = 0; bus.clr_ovf = 0;

    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_empty", bus.empty, 1);
    chk("rst_full", bus.full, 0);
    chk("rst_afull", bus.afull, 0);
    chk("rst_count", bus.count, 0);
    chk("rst_ovf", bus.overflow, 0);
    chk("rst_rvld", bus.rd_valid, 0);
    chk("rst_rdata", bus.rd_data, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Single character with parity error
    cyc(1, 8'hA5, 1, 0, 0, 0);
    chk("one_count1", bus.count, 1);
    chk("one_empty0", bus.empty, 0);
    cyc(0, 8'h00, 0, 0, 1, 0);
    chk("one_rvld", bus.rd_valid, 1);
    chk("one_data", bus.rd_data, 8'hA5);
    chk("one_pe", bus.rd_par_err, EXP_PE);
    chk("one_fe", bus.rd_frm_err, 0);
    chk("one_count0", bus.count, 0);
    chk("one_empty1", bus.empty, 1);
    cyc(0, 8'h00, 0, 0, 0, 0);
    chk("one_rvld_pulse", bus.rd_valid, 0);
    chk("one_hold", bus.rd_data, 8'hA5);

    // Fill to full, afull threshold, overflow drop
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1, 8'(i), 0, 0, 0, 0);
      if (i == 10) chk("afull_at11", bus.afull, 0);
      if (i == 11) chk("afull_at12", bus.afull, 1);
    end
    chk("fill_full", bus.full, 1);
    chk("fill_count", bus.count, 16);
    cyc(1, 8'hEE, 0, 0, 0, 0);
    chk("drop_ovf", bus.overflow, 1);
    chk("drop_count", bus.count, 16);
    for (int i = 0; i < DEPTH; i++) begin
      cyc(0, 8'h00, 0, 0, 1, 0);
      chk("drain_data", bus.rd_data, 32'(i));
    end
    chk("drain_empty", bus.empty, 1);
    chk("drain_ovf_sticky", bus.overflow, 1);
    cyc(0, 8'h00, 0, 0, 0, 1);
    chk("clr_ovf", bus.overflow, 0);

    // Full with simultaneous write and read; drop vs clear priority
    for (int i = 0; i < DEPTH; i++) cyc(1, 8'(8'h10 + i), 0, 0, 0, 0);
    cyc(1, 8'h55, 0, 0, 1, 0);
    chk("fullrw_ovf", bus.overflow, 0);
    chk("fullrw_count", bus.count, 16);
    chk("fullrw_data", bus.rd_data, 8'h10);
    chk("fullrw_rvld", bus.rd_valid, 1);
    cyc(1, 8'h66, 0, 0, 0, 1);
    chk("setwins_ovf", bus.overflow, 1);
    chk("setwins_count", bus.count, 16);
    for (int i = 1; i < DEPTH; i++) begin
      cyc(0, 8'h00, 0, 0, 1, 0);
      chk("fullrw_drain", bus.rd_data, 32'(8'h10 + i));
    end
    cyc(0, 8'h00, 0, 0, 1, 0);
    chk("fullrw_last", bus.rd_data, 8'h55);
    chk("fullrw_empty", bus.empty, 1);
    cyc(0, 8'h00, 0, 0, 0, 1);

    // Write into empty with same-cycle read
    cyc(1, 8'h3C, 0, 0, 1, 0);
    chk("emptyrw_count", bus.count, 1);
    chk("emptyrw_rvld", bus.rd_valid, 0);
    cyc(0, 8'h00, 0, 0, 1, 0);
    chk("emptyrw_data", bus.rd_data, 8'h3C);
    chk("emptyrw_rvld2", bus.rd_valid, 1);

    // 40 write/pop pairs: pointers wrap twice
    for (int i = 0; i < 40; i++) begin
      cyc(1, 8'(8'h80 + i), 0, 0, 0, 0);
      cyc(0, 8'h00, 0, 0, 1, 0);
      chk("wrap_data", bus.rd_data, 32'(8'h80 + i));
    end
    chk("wrap_empty", bus.empty, 1);

    // Asynchronous reset with entries held
    for (int i = 0; i < 5; i++) cyc(1, 8'(8'hC0 + i), 0, 0, 0, 0);
    chk("pre_rst_count", bus.count, 5);
    #2 rst = 1'b1;
    #1;
    chk("arst_count", bus.count, 0);
    chk("arst_empty", bus.empty, 1);
    chk("arst_full", bus.full, 0);
    chk("arst_afull", bus.afull, 0);
    chk("arst_rdata", bus.rd_data, 0);
    chk("arst_rvld", bus.rd_valid, 0);
    chk("arst_ovf", bus.overflow, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    cyc(0, 8'h00, 0, 0, 1, 0);
    chk("post_rst_rvld", bus.rd_valid, 0);
    chk("post_rst_count", bus.count, 0);
    chk("post_rst_rdata", bus.rd_data, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive buffer sitting directly downstream of the UART asynchronous receiver, between it and the APB register interface. It captures each completed character, with its parity and framing error flags, on the receiver's one-cycle write strobe. Characters are held in a circular buffer and presented to the register bank in order, with status flags, an almost-full threshold for interrupt generation and a sticky overflow flag.

## Interface
- DEPTH, 16 — number of entries; power of two, 4..256.
- AFULL_LVL, 12 — count at or above which `afull` asserts; 1..DEPTH.
- CLK  in  1  system clock; all logic on the rising edge.
- RESET  in  1  asynchronous, active-high reset.
- wr_en  in  1  one-cycle strobe from the receiver: character complete.
- wr_data  in  8  received character.
- wr_par_err  in  1  parity error flag for this character.
- wr_frm_err  in  1  framing (stop-bit) error flag for this character.
- rd_en  in  1  one-cycle pop request from the register bank.
- clr_ovf  in  1  clears the sticky overflow flag.
- rd_data  out  8  last popped character.
- rd_par_err  out  1  parity flag of the last popped character.
- rd_frm_err  out  1  framing flag of the last popped character.
- rd_valid  out  1  one-cycle pulse: rd_* were updated this cycle.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- afull  out  1  count >= AFULL_LVL.
- count  out  $clog2(DEPTH)+1  number of entries held.
- overflow  out  1  sticky flag: a character was dropped.

## Operation
- Storage: circular array of DEPTH entries, each {frm_err, par_err, data[7:0]}. Write pointer and read pointer are $clog2(DEPTH) bits wide and wrap modulo DEPTH.
- Write accepted: wr_en=1 and (not full, or rd_en=1 in the same cycle). The entry is stored at wptr and wptr increments.
- Write while full with no read: the character is dropped, pointers are unchanged, and overflow is set to 1.
- Read accepted: rd_en=1 and not empty. The head entry is registered into rd_*, rd_valid pulses, and rptr increments.
- rd_en while empty is ignored: rd_* hold their values, rd_valid stays 0, and no error is flagged.
- Simultaneous accepted read and write: count is unchanged, the read returns the old head, and the write lands at the tail.
- Write to an empty FIFO and read in the same cycle: the write is accepted and the read is ignored, because empty is evaluated before the edge.
- count is registered. It increments on write-only, decrements on read-only, and holds otherwise. It never exceeds DEPTH and never underflows.
- clr_ovf clears overflow. If clr_ovf and a dropped write occur in the same cycle, set wins and overflow = 1.
- Reset, including mid-operation: pointers = 0, count = 0, rd_data = 8'h00, rd_par_err = rd_frm_err = 0, rd_valid = 0, overflow = 0. The result is empty = 1, full = 0, afull = 0. Array contents are not reset.

## Timing
- Write latency: an entry written at edge N is visible in count/empty/full after edge N and can be popped by rd_en in cycle N+1.
- Read latency: rd_en sampled at edge N means rd_* and rd_valid are valid after edge N, for one cycle of rd_valid. rd_* hold until the next accepted read.
- empty, full and afull are decoded combinationally from registered count. They carry no extra latency beyond count.
- Throughput: one write and one read per cycle, sustained.

## Configuration
- UART_RX_FIFO_ERR_EN defined: the error flags are stored per entry (10-bit entries). rd_par_err and rd_frm_err follow the popped entry.
- Undefined: entries are 8 bits. wr_par_err and wr_frm_err are ignored. rd_par_err and rd_frm_err are tied to 0.
- The ports exist in both builds.

## Structure
- Shared package uart_pkg holds:
  - the entry width constants (UART_DATA_W = 8, UART_ENTRY_W = 10 or 8 per the macro);
  - the entry struct typedef {frm_err, par_err, data};
  - the default DEPTH and AFULL_LVL.
- One sub-module, uart_fifo_ram: a simple dual-port array with one write port and a registered read port, parameterised by width and depth. Pointer, count and flag logic stay in uart_rx_fifo.

## Test plan
- Reset, then write 8'hA5 with par_err=1 (ERR_EN build), then pop → rd_data = A5 and rd_par_err = 1. rd_valid pulses one cycle; count goes 0→1→0; empty returns to 1.
- Fill DEPTH = 16 with 8'h00..8'h0F → full = 1 and count = 16. afull asserts when count reaches 12. The 17th write sets overflow and is dropped. Draining returns 00..0F in order; clr_ovf clears overflow.
- With the FIFO full, apply wr_en and rd_en in the same cycle → overflow stays 0 and count stays 16. The popped value is the old head; the new byte is popped last.
- Empty FIFO, wr_en(8'h3C) and rd_en in the same cycle → count = 1, rd_valid = 0. The next rd_en returns 3C.
- Run 40 write/pop pairs with DEPTH = 16 → pointers wrap; data order is preserved with no loss.
- Assert RESET with count = 5 → all outputs reach their reset values immediately. The next pop on the empty FIFO produces no rd_valid.
